// File: rtl/interrupt_acknowledge_controller.sv
// Interrupt acknowledge controller for an 8259-style interrupt unit.
// Resolves fixed-priority requests (IR0 highest, IR7 lowest) against the
// in-service register and raises INT to the CPU. It then runs the two-pulse
// INTA handshake: the first pulse latches the winner, sets its in-service bit
// and clears its request. The second pulse drives the vector onto the bus.
// A non-specific EOI, or auto-EOI at the end of the second pulse, retires the
// in-service bit.

module interrupt_acknowledge_controller #(
    parameter int ACK_PULSES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       interrupt_acknowledge_n,
    input  logic       end_of_interrupt,
    input  logic       auto_eoi_config,
    input  logic [4:0] vector_base,
    output logic       interrupt_out,
    output logic       freeze,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [7:0] vector_out,
    output logic       vector_valid
);

    // Only the two-pulse handshake is implemented; anything else must not build.
    generate
        if (ACK_PULSES != 2) begin : g_illegal_ack_pulses
            $error("interrupt_acknowledge_controller: ACK_PULSES must be 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_ACK1    = 3'd2,
        ST_WAIT2   = 3'd3,
        ST_ACK2    = 3'd4
    } state_t;

    // Index of the lowest set bit, which is the highest priority level.
    // An all-zero input returns 7; callers qualify the result with a separate
    // "any bit set" flag.
    function automatic logic [2:0] lowest_set_index(input logic [7:0] value);
        logic [2:0] index;
        index = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (value[i]) begin
                index = 3'(i);
            end
        end
        return index;
    endfunction

    // Keeps only the lowest set bit, which is the highest priority one.
    function automatic logic [7:0] isolate_lowest(input logic [7:0] value);
        return value & (~value + 8'd1);
    endfunction

    // One-hot mask for a priority level.
    function automatic logic [7:0] level_onehot(input logic [2:0] level);
        return 8'd1 << level;
    endfunction

    state_t     state_r;
    logic       inta_prev_r;
    logic [2:0] level_r;
    logic       spurious_r;

    logic       inta_fall_s;
    logic       inta_rise_s;
    logic [7:0] candidates_s;
    logic       candidate_any_s;
    logic [2:0] candidate_index_s;
    logic       isr_any_s;
    logic [2:0] isr_index_s;
    logic       request_s;
    logic [7:0] isr_set_s;
    logic [7:0] isr_auto_clear_s;
    logic [7:0] isr_after_eoi_s;
    logic [7:0] isr_next_s;

    // INTA edge detection against the previous-cycle sample.
    always_comb begin
        inta_fall_s = inta_prev_r & ~interrupt_acknowledge_n;
        inta_rise_s = ~inta_prev_r & interrupt_acknowledge_n;
    end

    // Priority resolution of unmasked requests against in-service levels.
    // An in-service level blocks itself and every lower-priority level.
    always_comb begin
        candidates_s      = interrupt_request_register & ~interrupt_mask;
        candidate_any_s   = |candidates_s;
        candidate_index_s = lowest_set_index(candidates_s);
        isr_any_s         = |in_service_register;
        isr_index_s       = lowest_set_index(in_service_register);
        if (candidate_any_s) begin
            if (isr_any_s) begin
                request_s = (candidate_index_s < isr_index_s);
            end else begin
                request_s = 1'b1;
            end
        end else begin
            request_s = 1'b0;
        end
    end

    // In-service register next value. The EOI acts on the existing contents
    // first. The bit being retired by auto-EOI is then removed. The newly
    // acknowledged level is ORed in last, so it survives a same-cycle EOI.
    always_comb begin
        if ((state_r == ST_PENDING) && inta_fall_s && candidate_any_s) begin
            isr_set_s = level_onehot(candidate_index_s);
        end else begin
            isr_set_s = 8'd0;
        end

        if ((state_r == ST_ACK2) && inta_rise_s && auto_eoi_config && !spurious_r) begin
            isr_auto_clear_s = level_onehot(level_r);
        end else begin
            isr_auto_clear_s = 8'd0;
        end

        if (end_of_interrupt) begin
            isr_after_eoi_s = in_service_register & ~isolate_lowest(in_service_register);
        end else begin
            isr_after_eoi_s = in_service_register;
        end

        isr_next_s = (isr_after_eoi_s & ~isr_auto_clear_s) | isr_set_s;
    end

    // Acknowledge sequencer with registered outputs and in-service register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r                 <= ST_IDLE;
            inta_prev_r             <= 1'b1;
            level_r                 <= 3'd0;
            spurious_r              <= 1'b0;
            interrupt_out           <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= 8'd0;
            in_service_register     <= 8'd0;
            vector_out              <= 8'd0;
            vector_valid            <= 1'b0;
        end else begin
            inta_prev_r             <= interrupt_acknowledge_n;
            in_service_register     <= isr_next_s;
            clear_interrupt_request <= 8'd0;

            case (state_r)
                ST_IDLE: begin
                    // INTA activity here is stray and deliberately ignored.
                    if (request_s) begin
                        interrupt_out <= 1'b1;
                        state_r       <= ST_PENDING;
                    end
                end

                ST_PENDING: begin
                    // INT stays asserted even if the request disappears; the
                    // CPU will still run the handshake and gets a spurious
                    // level-7 vector in that case.
                    if (inta_fall_s) begin
                        interrupt_out <= 1'b0;
                        freeze        <= 1'b1;
                        state_r       <= ST_ACK1;
                        if (candidate_any_s) begin
                            level_r                 <= candidate_index_s;
                            spurious_r              <= 1'b0;
                            clear_interrupt_request <= isr_set_s;
                        end else begin
                            level_r    <= 3'd7;
                            spurious_r <= 1'b1;
                        end
                    end
                end

                ST_ACK1: begin
                    if (inta_rise_s) begin
                        state_r <= ST_WAIT2;
                    end
                end

                ST_WAIT2: begin
                    if (inta_fall_s) begin
                        vector_out   <= {vector_base, level_r};
                        vector_valid <= 1'b1;
                        state_r      <= ST_ACK2;
                    end
                end

                ST_ACK2: begin
                    if (inta_rise_s) begin
                        vector_valid <= 1'b0;
                        freeze       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    interrupt_out <= 1'b0;
                    freeze        <= 1'b0;
                    vector_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/interrupt_acknowledge_controller.md
INTERRUPT_ACKNOWLEDGE_CONTROLLER -- requirements
Module: interrupt_acknowledge_controller

Interface
REQ-001 SHALL have parameter: ACK_PULSES, default 2, number of INTA pulses per acknowledge cycle (legal values 2 only; other values are a synthesis error).
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: interrupt_request_register  input  8  latched requests from the IRR block.
REQ-005 SHALL have port: interrupt_mask  input  8  IMR; 1 masks the level.
REQ-006 SHALL have port: interrupt_acknowledge_n  input  1  INTA pin, already synchronised to clock, active-low.
REQ-007 SHALL have port: end_of_interrupt  input  1  one-cycle non-specific EOI pulse.
REQ-008 SHALL have port: auto_eoi_config  input  1  1 = clear ISR bit at end of second INTA.
REQ-009 SHALL have port: vector_base  input  5  ICW2 bits T7..T3.
REQ-010 SHALL have port: interrupt_out  output  1  INT pin to CPU.
REQ-011 SHALL have port: freeze  output  1  holds IRR during acknowledge.
REQ-012 SHALL have port: clear_interrupt_request  output  8  one-cycle clear pulse to IRR.
REQ-013 SHALL have port: in_service_register  output  8  ISR.
REQ-014 SHALL have port: vector_out  output  8  interrupt vector.
REQ-015 SHALL have port: vector_valid  output  1  data-bus drive enable for vector_out.

Function
REQ-016 SHALL register interrupt_acknowledge_n each cycle; falling edge = prev 1, now 0; rising edge = prev 0, now 1.
REQ-017 SHALL compute candidates = interrupt_request_register & ~interrupt_mask, with fixed priority IR0 highest, IR7 lowest.
REQ-018 SHALL raise "request" when the highest candidate is of strictly higher priority than the highest set ISR bit (an ISR bit blocks equal and lower levels).
REQ-019 SHALL implement FSM states IDLE, PENDING, ACK1, WAIT2, ACK2.
REQ-020 IDLE: on request, SHALL set interrupt_out=1 next cycle and go to PENDING.
REQ-021 PENDING: interrupt_out SHALL stay 1 (even if request drops); on INTA falling edge, SHALL latch winning level, set freeze=1, clear interrupt_out, go to ACK1.
REQ-022 On that same edge with a valid winner, SHALL set its ISR bit and pulse its clear_interrupt_request bit for exactly one cycle.
REQ-023 If no candidate exists at that edge (spurious), SHALL latch level 7, set no ISR bit, and pulse no clear bit.
REQ-024 ACK1: on INTA rising edge, SHALL go to WAIT2.
REQ-025 WAIT2: on INTA falling edge, SHALL drive vector_out={vector_base, level[2:0]}, set vector_valid=1, and go to ACK2.
REQ-026 ACK2: on INTA rising edge, SHALL clear vector_valid and freeze, clear the latched ISR bit if auto_eoi_config=1 and not spurious, and go to IDLE.
REQ-027 SHALL ignore INTA edges in IDLE.
REQ-028 SHALL clear the highest-priority set ISR bit on end_of_interrupt in any state; with ISR=0, EOI is a no-op.
REQ-029 SHALL, when EOI and an ISR set occur in the same cycle, apply EOI to the pre-existing ISR first, then OR in the new bit.
REQ-030 SHALL hold vector_out at its last value when vector_valid=0.

Reset
REQ-031 SHALL, when reset_n=0 at a clock edge (including mid-acknowledge), go to IDLE and zero interrupt_out, freeze, clear_interrupt_request, in_service_register, vector_out, vector_valid, and the INTA history register (history reset value 1).

Verification
REQ-032 SHALL cover: IRR=8'h24, IMR=0, vector_base=5'h10, two INTA pulses -> INT high; ISR=8'h04; clear pulse 8'h04; vector_out=8'h82 during 2nd INTA; freeze high from 1st fall to 2nd rise.
REQ-033 SHALL cover: ISR=8'h04, IRR=8'h08 -> no INT; then EOI -> ISR=0, INT asserts for IR3.
REQ-034 SHALL cover: IRR=8'h01 drops to 0 before 1st INTA -> ISR unchanged, no clear pulse, vector_out={vector_base,3'd7}.
REQ-035 SHALL cover: auto_eoi_config=1, IRR=8'h10 -> ISR bit4 set after 1st INTA, ISR=0 after 2nd INTA rise.
REQ-036 SHALL cover: reset_n=0 while in WAIT2 -> next cycle all outputs 0, FSM IDLE; subsequent INTA edges ignored.
REQ-037 SHALL cover: ISR=8'h06 with EOI pulsed in the same cycle as a new ISR set of bit0 -> ISR=8'h05.
